// File: rtl/ms_alu_pkg.sv
// Shared constants and types for the multi-stage ALU controller.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package ms_alu_pkg;

  // Instruction geometry.
  localparam int INSTR_W = 10;
  localparam int REG_W   = 3;
  localparam int OPC_MSB = 9;
  localparam int OPC_LSB = 7;
  localparam int RX_MSB  = 6;
  localparam int RX_LSB  = 4;
  localparam int RY_MSB  = 3;
  localparam int RY_LSB  = 1;

  // Opcodes.
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_INV  = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_OR   = 3'b110;
  localparam logic [2:0] OP_XOR  = 3'b111;

  // ALU function codes.
  localparam logic [2:0] FN_ADD = 3'b000;
  localparam logic [2:0] FN_SUB = 3'b001;
  localparam logic [2:0] FN_INV = 3'b010;
  localparam logic [2:0] FN_AND = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_XOR = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4
  } state_t;

  // Opcode to ALU function; LOAD/MOV never use the ALU so they map to ADD.
  function automatic logic [2:0] fn_map(input logic [2:0] op);
    logic [2:0] fn;
    fn = FN_ADD;
    case (op)
      OP_SUB:  fn = FN_SUB;
      OP_INV:  fn = FN_INV;
      OP_AND:  fn = FN_AND;
      OP_OR:   fn = FN_OR;
      OP_XOR:  fn = FN_XOR;
      default: fn = FN_ADD;
    endcase
    return fn;
  endfunction

endpackage

// File: rtl/ms_onehot_dec.sv
// Index to one-hot decoder with enable; all-zero output when disabled.
// Latency: combinational.
// Backpressure: none.
module ms_onehot_dec #(
  parameter int RW = 3
) (
  input  logic [RW-1:0]      i_idx,
  input  logic               i_en,
  output logic [(1<<RW)-1:0] o_onehot
);

  localparam int NREG = 1 << RW;

  // Single hot bit at the index position, gated by the enable.
  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot = NREG'(1) << i_idx;
  end

endmodule

// File: rtl/ms_alu_ctrl.sv
// Sequencer for the A/G/Q ALU datapath and shared register bus.
// Latency: 1 cycle (LOAD/MOV), 3 (INV), 4 (ADD/SUB/AND/OR/XOR) from acceptance to Done.
// Backpressure: Exec is accepted only in IDLE; requests while Busy are dropped.
module ms_alu_ctrl
  import ms_alu_pkg::*;
#(
  parameter int IW = 10,
  parameter int RW = 3
) (
  input  logic                CLKb,
  input  logic                RSTb,
  input  logic [IW-1:0]       INSTR,
  input  logic                Exec,
  output logic                Ain,
  output logic                Gin,
  output logic                Gout,
  output logic [2:0]          FN,
  output logic [(1<<RW)-1:0]  Rin,
  output logic [(1<<RW)-1:0]  Rout,
  output logic                Extern,
  output logic                Qout,
  output logic                Busy,
  output logic                Done
);

  localparam int NREG = 1 << RW;

  state_t        r_state;
  state_t        w_next;
  logic [IW-1:0] r_ir;

  logic [2:0]    w_op;
  logic [2:0]    w_in_op;
  logic [RW-1:0] w_rx;
  logic [RW-1:0] w_ry;
  logic          w_rin_en;
  logic [RW-1:0] w_rin_idx;
  logic          w_rout_en;
  logic [RW-1:0] w_rout_idx;

  assign w_op    = r_ir[OPC_MSB:OPC_LSB];
  assign w_rx    = r_ir[RX_MSB:RX_LSB];
  assign w_ry    = r_ir[RY_MSB:RY_LSB];
  assign w_in_op = INSTR[OPC_MSB:OPC_LSB];

  // State register and instruction latch; IR only captures on acceptance.
  always_ff @(posedge CLKb or negedge RSTb) begin
    if (!RSTb) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && Exec) r_ir <= INSTR;
    end
  end

  // Next-state and strobe decode from registered state and IR only.
  always_comb begin
    w_next     = r_state;
    Ain        = 1'b0;
    Gin        = 1'b0;
    Gout       = 1'b0;
    Extern     = 1'b0;
    Qout       = 1'b0;
    Done       = 1'b0;
    w_rin_en   = 1'b0;
    w_rin_idx  = w_rx;
    w_rout_en  = 1'b0;
    w_rout_idx = w_ry;
    case (r_state)
      ST_IDLE: begin
        // INV has no A operand, so it starts directly at the G load.
        if (Exec) w_next = (w_in_op == OP_INV) ? ST_T2 : ST_T1;
      end
      ST_T1: begin
        if (w_op == OP_LOAD) begin
          Extern   = 1'b1;
          w_rin_en = 1'b1;
          Done     = 1'b1;
          w_next   = ST_IDLE;
        end else if (w_op == OP_MOV) begin
          w_rout_en = 1'b1;
          w_rin_en  = 1'b1;
          Done      = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_rout_en  = 1'b1;
          w_rout_idx = w_rx;
          Ain        = 1'b1;
          w_next     = ST_T2;
        end
      end
      ST_T2: begin
        w_rout_en = 1'b1;
        Gin       = 1'b1;
        w_next    = ST_T3;
      end
      ST_T3: begin
        // Q load is kept a full cycle after the G load so Q never sees stale G.
        Gout   = 1'b1;
        w_next = ST_T4;
      end
      ST_T4: begin
        Qout     = 1'b1;
        w_rin_en = 1'b1;
        Done     = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Busy covers every non-idle state; FN is held for the whole instruction.
  always_comb begin
    Busy = (r_state != ST_IDLE);
    FN   = Busy ? fn_map(w_op) : FN_ADD;
  end

  ms_onehot_dec #(.RW(RW)) u_rin_dec (
    .i_idx    (w_rin_idx),
    .i_en     (w_rin_en),
    .o_onehot (Rin)
  );

  ms_onehot_dec #(.RW(RW)) u_rout_dec (
    .i_idx    (w_rout_idx),
    .i_en     (w_rout_en),
    .o_onehot (Rout)
  );

endmodule

// File: tb/tb_ms_alu_ctrl.sv
// Directed bench for the ALU sequencer: per-cycle strobe vectors against hand-built expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_ms_alu_ctrl;

  logic       CLKb = 1'b0;
  logic       RSTb = 1'b0;
  logic [9:0] INSTR = '0;
  logic       Exec = 1'b0;
  logic       Ain, Gin, Gout, Extern, Qout, Busy, Done;
  logic [2:0] FN;
  logic [7:0] Rin, Rout;

  int errors = 0;
  int checks = 0;

  ms_alu_ctrl dut (
    .CLKb(CLKb), .RSTb(RSTb), .INSTR(INSTR), .Exec(Exec),
    .Ain(Ain), .Gin(Gin), .Gout(Gout), .FN(FN), .Rin(Rin), .Rout(Rout),
    .Extern(Extern), .Qout(Qout), .Busy(Busy), .Done(Done)
  );

  always #5 CLKb = ~CLKb;

  // Observed outputs as one vector: {Ain,Gin,Gout,FN,Rin,Rout,Extern,Qout,Busy,Done}.
  logic [25:0] obs;
  assign obs = {Ain, Gin, Gout, FN, Rin, Rout, Extern, Qout, Busy, Done};

  function automatic logic [25:0] ev(input logic a, input logic gi, input logic go,
                                     input logic [2:0] fn, input logic [7:0] ri,
                                     input logic [7:0] ro, input logic ex, input logic q,
                                     input logic b, input logic d);
    return {a, gi, go, fn, ri, ro, ex, q, b, d};
  endfunction

  task automatic cyc();
    @(posedge CLKb);
    #1;
  endtask

  task automatic test_reset();
    logic [25:0] exp_v [2];
    #2;
    checks++;
    if (obs !== 26'h0) begin
      errors++; $display("FAIL reset_hold obs=%h exp=%h", obs, 26'h0);
    end
    @(negedge CLKb); RSTb = 1'b1;
    cyc();
    checks++;
    if (obs !== 26'h0) begin
      errors++; $display("FAIL reset_idle obs=%h exp=%h", obs, 26'h0);
    end
    // Reset mid-ADD R1,R2 during T2.
    INSTR = 10'b010_001_010_0; Exec = 1'b1;
    cyc(); Exec = 1'b0;
    exp_v[0] = ev(1,0,0,3'b000,8'h00,8'h02,0,0,1,0);
    exp_v[1] = ev(0,1,0,3'b000,8'h00,8'h04,0,0,1,0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL rst_add_t%0d obs=%h exp=%h", i + 1, obs, exp_v[i]);
      end
      if (i == 0) cyc();
    end
    #2 RSTb = 1'b0;
    #1;
    checks++;
    if (obs !== 26'h0) begin
      errors++; $display("FAIL rst_async obs=%h exp=%h", obs, 26'h0);
    end
    @(negedge CLKb); RSTb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (obs !== 26'h0) begin
        errors++; $display("FAIL rst_after%0d obs=%h exp=%h", i, obs, 26'h0);
      end
    end
  endtask

  task automatic test_load();
    INSTR = 10'b000_011_000_0; Exec = 1'b1;
    cyc(); Exec = 1'b0;
    checks++;
    if (obs !== ev(0,0,0,3'b000,8'h08,8'h00,1,0,1,1)) begin
      errors++; $display("FAIL load_t1 obs=%h exp=%h", obs, ev(0,0,0,3'b000,8'h08,8'h00,1,0,1,1));
    end
    cyc();
    checks++;
    if (obs !== 26'h0) begin
      errors++; $display("FAIL load_idle obs=%h exp=%h", obs, 26'h0);
    end
  endtask

  task automatic test_add();
    logic [25:0] exp_v [5];
    exp_v[0] = ev(1,0,0,3'b000,8'h00,8'h02,0,0,1,0);
    exp_v[1] = ev(0,1,0,3'b000,8'h00,8'h04,0,0,1,0);
    exp_v[2] = ev(0,0,1,3'b000,8'h00,8'h00,0,0,1,0);
    exp_v[3] = ev(0,0,0,3'b000,8'h02,8'h00,0,1,1,1);
    exp_v[4] = 26'h0;
    INSTR = 10'b010_001_010_0; Exec = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(); Exec = 1'b0;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL add_c%0d obs=%h exp=%h", i + 1, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_inv();
    logic [25:0] exp_v [4];
    exp_v[0] = ev(0,1,0,3'b010,8'h00,8'h01,0,0,1,0);
    exp_v[1] = ev(0,0,1,3'b010,8'h00,8'h00,0,0,1,0);
    exp_v[2] = ev(0,0,0,3'b010,8'h20,8'h00,0,1,1,1);
    exp_v[3] = 26'h0;
    INSTR = 10'b100_101_000_0; Exec = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); Exec = 1'b0;
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL inv_c%0d obs=%h exp=%h", i + 1, obs, exp_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    INSTR = 10'b001_111_000_0; Exec = 1'b1;
    cyc();
    checks++;
    if (obs !== ev(0,0,0,3'b000,8'h80,8'h01,0,0,1,1)) begin
      errors++; $display("FAIL mov_t1 obs=%h exp=%h", obs, ev(0,0,0,3'b000,8'h80,8'h01,0,0,1,1));
    end
    INSTR = 10'b111_000_111_0;
    cyc();
    checks++;
    if (obs !== 26'h0) begin
      errors++; $display("FAIL b2b_idle obs=%h exp=%h", obs, 26'h0);
    end
    cyc();
    checks++;
    if (obs !== ev(1,0,0,3'b101,8'h00,8'h01,0,0,1,0)) begin
      errors++; $display("FAIL xor_t1 obs=%h exp=%h", obs, ev(1,0,0,3'b101,8'h00,8'h01,0,0,1,0));
    end
    n = 1;
    while (!Done && n < 10) begin
      cyc(); n++;
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL xor_latency got=%0d exp=4", n);
    end
    checks++;
    if (obs !== ev(0,0,0,3'b101,8'h01,8'h00,0,1,1,1)) begin
      errors++; $display("FAIL xor_t4 obs=%h exp=%h", obs, ev(0,0,0,3'b101,8'h01,8'h00,0,1,1,1));
    end
    Exec = 1'b0;
    cyc();
    checks++;
    if (obs !== 26'h0) begin
      errors++; $display("FAIL xor_idle obs=%h exp=%h", obs, 26'h0);
    end
  endtask

  task automatic test_sub_ignore();
    logic [25:0] exp_v [6];
    exp_v[0] = ev(1,0,0,3'b001,8'h00,8'h04,0,0,1,0);
    exp_v[1] = ev(0,1,0,3'b001,8'h00,8'h08,0,0,1,0);
    exp_v[2] = ev(0,0,1,3'b001,8'h00,8'h00,0,0,1,0);
    exp_v[3] = ev(0,0,0,3'b001,8'h04,8'h00,0,1,1,1);
    exp_v[4] = 26'h0;
    exp_v[5] = 26'h0;
    INSTR = 10'b011_010_011_0; Exec = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      // Pulse Exec with a LOAD on the bus while in T2; it must be ignored.
      if (i == 1) begin
        Exec = 1'b1; INSTR = 10'b000_011_000_0;
      end else begin
        Exec = 1'b0;
      end
      checks++;
      if (obs !== exp_v[i]) begin
        errors++; $display("FAIL sub_c%0d obs=%h exp=%h", i + 1, obs, exp_v[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_add();
    test_inv();
    test_back_to_back();
    test_sub_ignore();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ms_alu_ctrl.md
Name: ms_alu_ctrl

Overview:
- Control sequencer that drives the multi-stage ALU datapath (A register, G register, Q output register) and the shared 10-bit register bus.
- Latches one instruction, decodes it, and steps the ALU strobes Ain/Gin/Gout, the FN code, register-file select lines and bus-driver enables over 1–4 cycles.
- Sits between the instruction source (switches/testbench) and the register file plus ALU.
- Registered outputs update on posedge CLKb, so they are stable when the ALU samples on negedge CLKb.

Parameters:
- IW, 10, instruction width.
- RW, 3, register-index field width.
- NREG, 2**RW (8), register count; width of the one-hot select buses. Derived, not overridable.

Ports:
- CLKb  in  1  system clock. Controller uses the rising edge; the ALU and register file sample on the falling edge.
- RSTb  in  1  asynchronous, active-low reset.
- INSTR  in  IW  instruction word. [9:7] opcode, [6:4] Rx (destination / first operand), [3:1] Ry (second operand), [0] ignored.
- Exec  in  1  start request; sampled only in IDLE.
- Ain  out  1  load ALU A register from the bus.
- Gin  out  1  load ALU G register from the ALU result.
- Gout  out  1  load ALU Q register from G.
- FN  out  3  ALU function code: ADD=000, SUB=001, INV=010, AND=011, OR=100, XOR=101.
- Rin  out  NREG  one-hot register-file write enables.
- Rout  out  NREG  one-hot register-file bus-drive enables.
- Extern  out  1  external data drives the bus.
- Qout  out  1  ALU Q drives the bus.
- Busy  out  1  high from the cycle after acceptance through the Done cycle.
- Done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (RSTb=0, asynchronous): state=IDLE, IR=0. All outputs 0, FN=000.
- IDLE with Exec=1 at a posedge: INSTR is latched into IR, the FSM moves to T1 (or T2 for INV), and Busy=1. Exec in any other state is ignored.
- Opcodes:
  - 000 LOAD
  - 001 MOV
  - 010 ADD
  - 011 SUB
  - 100 INV
  - 101 AND
  - 110 OR
  - 111 XOR
- FN mapping: ADD→000, SUB→001, INV→010, AND→011, OR→100, XOR→101. FN is held at the mapped value for the whole instruction; it is 000 in IDLE.
- States: IDLE, T1, T2, T3, T4. Each state lasts exactly one cycle.
- LOAD: T1 asserts Extern and Rin[Rx], plus Done. Next state IDLE. Latency 1.
- MOV: T1 asserts Rout[Ry] and Rin[Rx], plus Done. Next state IDLE. Latency 1. If Rx==Ry, still perform the cycle.
- ADD/SUB/AND/OR/XOR:
  - T1: Rout[Rx], Ain.
  - T2: Rout[Ry], Gin.
  - T3: Gout.
  - T4: Qout, Rin[Rx], Done.
  - Latency 4.
- INV: skips T1 (A is unused). Sequence T2 → T3 → T4 with the same strobes as above. Latency 3.
- Gin and Gout are never asserted in the same cycle, because the ALU would otherwise pass the stale G.
- Bus exclusivity: at most one of Extern, Qout or any Rout bit is high in a cycle. Rin and Rout each have at most one hot bit.
- Done is high only in the final state. Next state is IDLE; Busy drops the cycle after Done.
- Back-to-back: Exec high during the Done cycle is not accepted. A new instruction is accepted at the next posedge while in IDLE, so the minimum gap between Done pulses is 2 cycles.
- INSTR changing during Busy has no effect, because IR holds the value.
- Reset mid-instruction: all strobes drop immediately (asynchronous). No Done is produced, and the partial register/ALU state is not restored.
- Outputs are decoded from the registered state and IR only, never from INSTR or Exec combinationally.

Decomposition:
- Shared package ms_alu_pkg holds:
  - the FN code constants (ADD..XOR);
  - the opcode constants (LOAD..XOR);
  - the state enum type;
  - the instruction field positions.
- ms_alu_ctrl comprises the FSM, IR, and output decode.
- One sub-module, ms_onehot_dec (RW-bit index → NREG one-hot with enable), instantiated twice, for Rin and Rout.

Test Plan:
- Reset mid-ADD: assert RSTb=0 during T2 → all outputs 0 asynchronously. After release, IDLE; Done never pulses.
- LOAD R3 (INSTR=10'b000_011_000_0), Exec=1 → next cycle Extern=1, Rin=8'b0000_1000, Done=1. Busy low one cycle later.
- ADD R1,R2 (INSTR=10'b010_001_010_0) → required cycle sequence:
  - T1: Rout=0000_0010, Ain=1.
  - T2: Rout=0000_0100, Gin=1, FN=000.
  - T3: Gout=1.
  - T4: Qout=1, Rin=0000_0010, Done=1.
- INV R5 (10'b100_101_000_0) → 3 cycles: T2 with Rout[0], Gin=1 and FN=010; then T3; then T4 with Rin=0010_0000 and Done.
- MOV R7,R0 followed immediately by Exec held high with XOR R0,R7:
  - MOV completes in 1 cycle.
  - XOR is accepted only in IDLE.
  - XOR's FN=101 and its Done arrives exactly 4 cycles after acceptance.
- Exec pulsed during SUB's T2, with INSTR changed to LOAD → ignored. SUB finishes with FN=001; no Extern is asserted.
